rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter_if.sv | 28 ++
 rtl/rf_write_arbiter.sv | 90 +++++++++
 tb/tb_rf_write_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Request and register-file write bundle between two write requesters and rf_write_arbiter.
interface rf_write_arbiter_if;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  logic              a_valid;
  logic [REG_W-1:0]  a_reg;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [REG_W-1:0]  b_reg;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              reg_write;
  logic [REG_W-1:0]  write_reg;
  logic [DATA_W-1:0] write_data;
  logic              init_busy;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready, reg_write, write_reg, write_data, init_busy
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready, reg_write, write_reg, write_data, init_busy
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-requester round-robin register-file write arbiter with optional post-reset
// clear of registers 1..31 and a registered one-write-per-cycle output stage.
module rf_write_arbiter #(
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  rf_write_arbiter_if.slave  bus
);
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic       LAST_A  = 1'b0;
  localparam logic       LAST_B  = 1'b1;
  localparam logic [REG_W-1:0] CNT_LAST = REG_W'(31);

  logic [0:0]        state_q, state_d;
  logic [REG_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              reg_write_q, reg_write_d;
  logic [REG_W-1:0]  write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              a_ready_c, b_ready_c;

  // Grant decision and next output stage
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    a_ready_c    = 1'b0;
    b_ready_c    = 1'b0;

    if (state_q == ST_INIT) begin
      reg_write_d  = 1'b1;
      write_reg_d  = cnt_q;
      write_data_d = '0;
      cnt_d        = cnt_q + REG_W'(1);
      if (cnt_q == CNT_LAST) state_d = ST_RUN;
    end else if (!rst) begin
      // On contention the requester not named by last wins
      if (bus.a_valid && (!bus.b_valid || last_q == LAST_B)) begin
        a_ready_c = 1'b1;
      end else if (bus.b_valid) begin
        b_ready_c = 1'b1;
      end

      if (a_ready_c) begin
        last_d       = LAST_A;
        reg_write_d  = (bus.a_reg != '0);
        write_reg_d  = bus.a_reg;
        write_data_d = bus.a_data;
      end else if (b_ready_c) begin
        last_d       = LAST_B;
        reg_write_d  = (bus.b_reg != '0);
        write_reg_d  = bus.b_reg;
        write_data_d = bus.b_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT_CLEAR ? ST_INIT : ST_RUN;
      cnt_q        <= REG_W'(1);
      last_q       <= LAST_B;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign bus.a_ready    = a_ready_c;
  assign bus.b_ready    = b_ready_c;
  assign bus.init_busy  = (state_q == ST_INIT);
  assign bus.reg_write  = reg_write_q;
  assign bus.write_reg  = write_reg_q;
  assign bus.write_data = write_data_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized and directed bench for rf_write_arbiter: one instance with the clear
// sequence, one without, both driven by the same stimulus and tracked by a reference model.
module tb_rf_write_arbiter;
  logic        clk;
  logic        rst;
  logic        a_valid, b_valid;
  logic [4:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;

  int n_chk;
  int n_fail;

  rf_write_arbiter_if if0 ();
  rf_write_arbiter_if if1 ();

  assign if0.a_valid = a_valid;
  assign if0.a_reg   = a_reg;
  assign if0.a_data  = a_data;
  assign if0.b_valid = b_valid;
  assign if0.b_reg   = b_reg;
  assign if0.b_data  = b_data;
  assign if1.a_valid = a_valid;
  assign if1.a_reg   = a_reg;
  assign if1.a_data  = a_data;
  assign if1.b_valid = b_valid;
  assign if1.b_reg   = b_reg;
  assign if1.b_data  = b_data;

  rf_write_arbiter #(.INIT_CLEAR(1'b1)) u_dut_clr (.clk(clk), .rst(rst), .bus(if0));
  rf_write_arbiter #(.INIT_CLEAR(1'b0)) u_dut_noclr (.clk(clk), .rst(rst), .bus(if1));

  logic        o_a_ready [2];
  logic        o_b_ready [2];
  logic        o_busy    [2];
  logic        o_rw      [2];
  logic [4:0]  o_wr      [2];
  logic [31:0] o_wd      [2];

  assign o_a_ready[0] = if0.a_ready;
  assign o_b_ready[0] = if0.b_ready;
  assign o_busy[0]    = if0.init_busy;
  assign o_rw[0]      = if0.reg_write;
  assign o_wr[0]      = if0.write_reg;
  assign o_wd[0]      = if0.write_data;
  assign o_a_ready[1] = if1.a_ready;
  assign o_b_ready[1] = if1.b_ready;
  assign o_busy[1]    = if1.init_busy;
  assign o_rw[1]      = if1.reg_write;
  assign o_wr[1]      = if1.write_reg;
  assign o_wd[1]      = if1.write_data;

  // Reference model: what each instance is expected to show, as of the current cycle
  bit          m_init  [2];
  bit          m_clr   [2];
  int          m_nxt   [2];
  bit          m_lastb [2];
  bit          m_rw    [2];
  bit          m_known [2];
  int          m_wr    [2];
  logic [31:0] m_wd    [2];
  logic        obs_a   [2];
  logic        obs_b   [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: check and advance the model at negedge, return just after posedge
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int          g;
      int          r;
      logic [31:0] d;
      bit          ea, eb;
      string       p;
      g  = 0;
      ea = 1'b0;
      eb = 1'b0;
      p  = $sformatf("d%0d_", k);
      if (m_init[k]) begin
        check_eq({p, "init_busy"}, 32'(o_busy[k]), 32'(m_clr[k]));
        check_eq({p, "reg_write"}, 32'(o_rw[k]), 32'(m_rw[k]));
        if (m_known[k]) begin
          check_eq({p, "write_reg"}, 32'(o_wr[k]), 32'(m_wr[k]));
          check_eq({p, "write_data"}, o_wd[k], m_wd[k]);
        end
      end
      if (rst) begin
        m_init[k]  = 1'b1;
        m_clr[k]   = (k == 0);
        m_nxt[k]   = 1;
        m_lastb[k] = 1'b1;
        m_rw[k]    = 1'b0;
        m_known[k] = 1'b1;
        m_wr[k]    = 0;
        m_wd[k]    = 32'h0;
      end else if (m_clr[k]) begin
        m_rw[k]    = 1'b1;
        m_known[k] = 1'b1;
        m_wr[k]    = m_nxt[k];
        m_wd[k]    = 32'h0;
        if (m_nxt[k] == 31) m_clr[k] = 1'b0;
        m_nxt[k]   = m_nxt[k] + 1;
      end else begin
        if (a_valid && b_valid) g = m_lastb[k] ? 1 : 2;
        else if (a_valid)       g = 1;
        else if (b_valid)       g = 2;
        ea = (g == 1);
        eb = (g == 2);
        if (g == 0) begin
          m_rw[k] = 1'b0;
        end else begin
          r = (g == 1) ? int'(a_reg) : int'(b_reg);
          d = (g == 1) ? a_data : b_data;
          m_lastb[k] = (g == 2);
          m_rw[k]    = (r != 0);
          if (r != 0) begin
            m_known[k] = 1'b1;
            m_wr[k]    = r;
            m_wd[k]    = d;
          end else begin
            m_known[k] = 1'b0;
          end
        end
      end
      if (m_init[k]) begin
        check_eq({p, "a_ready"}, 32'(o_a_ready[k]), 32'(ea));
        check_eq({p, "b_ready"}, 32'(o_b_ready[k]), 32'(eb));
      end
      obs_a[k] = o_a_ready[k];
      obs_b[k] = o_b_ready[k];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
  endtask

  initial begin
    int  writes;
    bit  found;
    n_chk  = 0;
    n_fail = 0;
    for (int k = 0; k < 2; k++) begin
      m_init[k] = 1'b0; m_clr[k] = 1'b0; m_nxt[k] = 1; m_lastb[k] = 1'b1;
      m_rw[k] = 1'b0; m_known[k] = 1'b0; m_wr[k] = 0; m_wd[k] = 32'h0;
    end

    // Reset with B already pending: no-clear instance accepts it at once
    rst = 1'b1;
    set_req(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h0000_0011);
    step();
    step();
    rst = 1'b0;
    step();
    check_eq("noclr_first_b_ready", 32'(obs_b[1]), 32'd1);
    check_eq("clr_held_b_ready", 32'(obs_b[0]), 32'd0);
    check_eq("noclr_write_reg3", 32'(if1.write_reg), 32'd3);
    check_eq("noclr_write_data11", if1.write_data, 32'h0000_0011);
    check_eq("clr_first_write_reg1", 32'(if0.write_reg), 32'd1);
    set_req(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Pulse reset while register 12 is being cleared
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (if0.reg_write === 1'b1 && if0.write_reg === 5'd12) found = 1'b1;
      else step();
    end
    check_eq("wait_clear_reg12", 32'(found), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_mid_clear_rw0", 32'(if0.reg_write), 32'd0);
    set_req(1'b1, 5'd5, 32'hAAAA_0000, 1'b1, 5'd6, 32'hBBBB_0000);
    step();
    check_eq("restart_reg1", 32'(if0.write_reg), 32'd1);

    // Count the restarted clear to completion; both requesters wait meanwhile
    writes = 1;
    found  = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (if0.reg_write === 1'b1) writes++;
      if (if0.write_reg === 5'd31) found = 1'b1;
    end
    check_eq("clear_done", 32'(found), 32'd1);
    check_eq("clear_write_count", 32'(writes), 32'd31);
    check_eq("busy_falls_at_31", 32'(if0.init_busy), 32'd0);

    // Contention from RUN entry: A, B, A
    step();
    check_eq("cont_g1_a", 32'(obs_a[0]), 32'd1);
    check_eq("cont_o1_reg", 32'(if0.write_reg), 32'd5);
    check_eq("cont_o1_data", if0.write_data, 32'hAAAA_0000);
    step();
    check_eq("cont_g2_b", 32'(obs_b[0]), 32'd1);
    check_eq("cont_o2_reg", 32'(if0.write_reg), 32'd6);
    check_eq("cont_o2_data", if0.write_data, 32'hBBBB_0000);
    step();
    check_eq("cont_g3_a", 32'(obs_a[0]), 32'd1);
    check_eq("cont_o3_reg", 32'(if0.write_reg), 32'd5);

    // Register-0 write is accepted then dropped
    set_req(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
    step();
    check_eq("r0_a_ready", 32'(obs_a[0]), 32'd1);
    check_eq("r0_dropped", 32'(if0.reg_write), 32'd0);

    // Make B the last grantee, then race both onto register 7
    set_req(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h0000_0009);
    step();
    set_req(1'b1, 5'd7, 32'h0000_0001, 1'b1, 5'd7, 32'h0000_0002);
    step();
    check_eq("race_first_data", if0.write_data, 32'h0000_0001);
    check_eq("race_first_reg", 32'(if0.write_reg), 32'd7);
    set_req(1'b0, 5'd7, 32'h0000_0001, 1'b1, 5'd7, 32'h0000_0002);
    step();
    check_eq("race_second_data", if0.write_data, 32'h0000_0002);
    set_req(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    step();

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      set_req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
      step();
    end
    rst = 1'b0;
    set_req(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
